// File: rtl/return_addr_stack.sv
// return_addr_stack: return-address stack for the fetch/decode path.
// Calls push pc+4, returns pop, and the top entry is offered as the
// predicted JALR target. Supports circular overwrite on overflow, sticky
// overflow/underflow flags and a single {tos, count} checkpoint.
//
// Ports:
//   clk, reset (async, active-low)
//   valid, is_jal, is_jalr, rd, rs1, pc : presented control-transfer instr
//   flush                               : empty the stack
//   ckpt_save / ckpt_restore            : checkpoint capture / reload
//   pred_valid, pred_target             : prediction from current top of stack
//   depth_count                         : number of live entries
//   overflow, underflow                 : sticky error flags
module return_addr_stack #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       valid,
  input  logic                       is_jal,
  input  logic                       is_jalr,
  input  logic [4:0]                 rd,
  input  logic [4:0]                 rs1,
  input  logic [XLEN-1:0]            pc,
  input  logic                       flush,
  input  logic                       ckpt_save,
  input  logic                       ckpt_restore,
  output logic                       pred_valid,
  output logic [XLEN-1:0]            pred_target,
  output logic [$clog2(DEPTH+1)-1:0] depth_count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_POPPUSH
  } op_e;

  logic [XLEN-1:0] mem [DEPTH];
  logic [PW-1:0]   tos_q, tos_d, ck_tos_q, ck_tos_d;
  logic [CW-1:0]   cnt_q, cnt_d, ck_cnt_q, ck_cnt_d;
  logic            ovf_q, ovf_d, unf_q, unf_d;

  logic            wr_en;
  logic [PW-1:0]   wr_addr;
  logic [XLEN-1:0] push_val;
  logic            rd_link, rs1_link;
  logic            full, empty, do_push;
  op_e             op;

  // x1 (ra) and x5 (t0) are the RISC-V link registers
  assign rd_link  = (rd == 5'd1) || (rd == 5'd5);
  assign rs1_link = (rs1 == 5'd1) || (rs1 == 5'd5);
  assign push_val = pc + XLEN'(4);
  assign full     = (cnt_q == CW'(DEPTH));
  assign empty    = (cnt_q == '0);

  // Link-hint decode of the presented instruction
  always_comb begin
    op = OP_NONE;
    if (valid) begin
      if (is_jal) begin
        if (rd_link) op = OP_PUSH;
      end else if (is_jalr) begin
        case ({rd_link, rs1_link})
          2'b01:   op = OP_POP;
          2'b10:   op = OP_PUSH;
          2'b11:   op = (rd == rs1) ? OP_PUSH : OP_POPPUSH;
          default: op = OP_NONE;
        endcase
      end
    end
  end

  // A POPPUSH on an empty stack degenerates into a plain push
  assign do_push = (op == OP_PUSH) || ((op == OP_POPPUSH) && empty);

  // Next-state: flush > restore > (save, op)
  always_comb begin
    tos_d    = tos_q;
    cnt_d    = cnt_q;
    ck_tos_d = ck_tos_q;
    ck_cnt_d = ck_cnt_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    wr_en    = 1'b0;
    wr_addr  = tos_q;

    if (flush) begin
      tos_d = PW'(DEPTH - 1);
      cnt_d = '0;
    end else if (ckpt_restore) begin
      tos_d = ck_tos_q;
      cnt_d = ck_cnt_q;
    end else begin
      if (ckpt_save) begin
        ck_tos_d = tos_q;
        ck_cnt_d = cnt_q;
      end
      if ((op == OP_POP || op == OP_POPPUSH) && empty) begin
        unf_d = 1'b1;
      end
      if (do_push) begin
        tos_d   = tos_q + PW'(1);
        wr_en   = 1'b1;
        wr_addr = tos_q + PW'(1);
        if (full) ovf_d = 1'b1;
        else      cnt_d = cnt_q + CW'(1);
      end else if (op == OP_POP && !empty) begin
        tos_d = tos_q - PW'(1);
        cnt_d = cnt_q - CW'(1);
      end else if (op == OP_POPPUSH) begin
        // non-empty: replace top in place
        wr_en   = 1'b1;
        wr_addr = tos_q;
      end
    end
  end

  // State and entry storage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tos_q    <= PW'(DEPTH - 1);
      cnt_q    <= '0;
      ck_tos_q <= PW'(DEPTH - 1);
      ck_cnt_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      tos_q    <= tos_d;
      cnt_q    <= cnt_d;
      ck_tos_q <= ck_tos_d;
      ck_cnt_q <= ck_cnt_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      if (wr_en) mem[wr_addr] <= push_val;
    end
  end

  // Prediction is combinational from registered state
  assign pred_valid  = !empty;
  assign pred_target = mem[tos_q];
  assign depth_count = cnt_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;

endmodule

// File: tb/tb_return_addr_stack.sv
// Self-checking bench for return_addr_stack against a behavioural model.
module tb_return_addr_stack;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam int unsigned SW    = 1 + XLEN + CW + 2;

  logic            clk;
  logic            reset;
  logic            valid, is_jal, is_jalr;
  logic [4:0]      rd, rs1;
  logic [XLEN-1:0] pc;
  logic            flush, ckpt_save, ckpt_restore;
  logic            pred_valid;
  logic [XLEN-1:0] pred_target;
  logic [CW-1:0]   depth_count;
  logic            overflow, underflow;

  int n_cmp = 0;
  int n_err = 0;

  return_addr_stack #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .valid        (valid),
    .is_jal       (is_jal),
    .is_jalr      (is_jalr),
    .rd           (rd),
    .rs1          (rs1),
    .pc           (pc),
    .flush        (flush),
    .ckpt_save    (ckpt_save),
    .ckpt_restore (ckpt_restore),
    .pred_valid   (pred_valid),
    .pred_target  (pred_target),
    .depth_count  (depth_count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [XLEN-1:0] m_mem [DEPTH];
  int              m_tos, m_cnt, m_ck_tos, m_ck_cnt;
  bit              m_ovf, m_unf;

  task automatic m_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_tos = DEPTH - 1; m_cnt = 0; m_ck_tos = DEPTH - 1; m_ck_cnt = 0;
    m_ovf = 0; m_unf = 0;
  endtask

  function automatic bit is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  task automatic m_push(input logic [XLEN-1:0] v);
    m_tos = (m_tos + 1) % DEPTH;
    m_mem[m_tos] = v;
    if (m_cnt == DEPTH) m_ovf = 1; else m_cnt++;
  endtask

  task automatic model_step(input bit v, input bit jal, input bit jalr,
                            input logic [4:0] d, input logic [4:0] s,
                            input logic [XLEN-1:0] p, input bit fl,
                            input bit sv, input bit rs);
    logic [XLEN-1:0] val;
    bit push, pop, swap;
    val = p + 32'd4;
    push = 0; pop = 0; swap = 0;
    if (v && jal && is_link(d)) push = 1;
    if (v && jalr) begin
      if (is_link(d) && is_link(s)) begin
        if (d == s) push = 1; else swap = 1;
      end else if (is_link(d)) push = 1;
      else if (is_link(s)) pop = 1;
    end
    if (fl) begin
      m_cnt = 0; m_tos = DEPTH - 1;
    end else if (rs) begin
      m_tos = m_ck_tos; m_cnt = m_ck_cnt;
    end else begin
      if (sv) begin m_ck_tos = m_tos; m_ck_cnt = m_cnt; end
      if (push) m_push(val);
      else if (pop) begin
        if (m_cnt == 0) m_unf = 1;
        else begin m_tos = (m_tos + DEPTH - 1) % DEPTH; m_cnt--; end
      end else if (swap) begin
        if (m_cnt == 0) begin m_unf = 1; m_push(val); end
        else m_mem[m_tos] = val;
      end
    end
  endtask

  function automatic logic [SW-1:0] model_vec();
    return {m_cnt != 0, m_mem[m_tos], CW'(m_cnt), m_ovf, m_unf};
  endfunction

  function automatic logic [SW-1:0] dut_vec();
    return {pred_valid, pred_target, depth_count, overflow, underflow};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic cycle(input bit v, input bit jal, input bit jalr,
                       input logic [4:0] d, input logic [4:0] s,
                       input logic [XLEN-1:0] p, input bit fl,
                       input bit sv, input bit rs);
    valid = v; is_jal = jal; is_jalr = jalr; rd = d; rs1 = s; pc = p;
    flush = fl; ckpt_save = sv; ckpt_restore = rs;
    @(posedge clk);
    model_step(v, jal, jalr, d, s, p, fl, sv, rs);
    #1;
    valid = 0; is_jal = 0; is_jalr = 0; flush = 0; ckpt_save = 0; ckpt_restore = 0;
  endtask

  task automatic call(input logic [XLEN-1:0] p);
    cycle(1, 1, 0, 5'd1, 5'd0, p, 0, 0, 0);
  endtask

  task automatic ret();
    cycle(1, 0, 1, 5'd0, 5'd1, 32'h0, 0, 0, 0);
  endtask

  task automatic idle(input bit sv, input bit rs, input bit fl);
    cycle(0, 0, 0, 5'd0, 5'd0, 32'h0, fl, sv, rs);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    m_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (dut_vec() !== {SW{1'b0}}) begin
      n_err++; $display("FAIL reset_outputs: got %h exp %h", dut_vec(), {SW{1'b0}});
    end
  endtask

  task automatic test_basic();
    do_reset();
    call(32'h0);
    n_cmp++;
    if ({pred_valid, pred_target, depth_count} !== {1'b1, 32'h4, CW'(1)}) begin
      n_err++; $display("FAIL basic_push: got pv=%0b tgt=%h cnt=%0d exp 1/00000004/1",
                        pred_valid, pred_target, depth_count);
    end
    ret();
    n_cmp++;
    if ({pred_valid, depth_count, underflow} !== {1'b0, CW'(0), 1'b0}) begin
      n_err++; $display("FAIL basic_pop: got pv=%0b cnt=%0d unf=%0b exp 0/0/0",
                        pred_valid, depth_count, underflow);
    end
  endtask

  task automatic test_nesting();
    logic [XLEN-1:0] exp_t [3];
    exp_t[0] = 32'h24; exp_t[1] = 32'h14; exp_t[2] = 32'h4;
    do_reset();
    call(32'h0); call(32'h10); call(32'h20);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({pred_target, depth_count} !== {exp_t[i], CW'(3 - i)}) begin
        n_err++; $display("FAIL nest_pop%0d: got tgt=%h cnt=%0d exp tgt=%h cnt=%0d",
                          i, pred_target, depth_count, exp_t[i], 3 - i);
      end
      ret();
    end
    n_cmp++;
    if (depth_count !== CW'(0)) begin
      n_err++; $display("FAIL nest_empty: got cnt=%0d exp 0", depth_count);
    end
  endtask

  task automatic test_overflow();
    logic [XLEN-1:0] e;
    do_reset();
    for (int k = 0; k < 9; k++) call(XLEN'(32'h100 * k));
    n_cmp++;
    if ({overflow, depth_count} !== {1'b1, CW'(8)}) begin
      n_err++; $display("FAIL ovf_flag: got ovf=%0b cnt=%0d exp 1/8", overflow, depth_count);
    end
    for (int k = 8; k >= 1; k--) begin
      e = XLEN'(32'h100 * k + 4);
      n_cmp++;
      if (pred_target !== e) begin
        n_err++; $display("FAIL ovf_pop_k%0d: got %h exp %h", k, pred_target, e);
      end
      ret();
    end
    n_cmp++;
    if (underflow !== 1'b0) begin
      n_err++; $display("FAIL ovf_no_unf: got unf=%0b exp 0", underflow);
    end
    ret();
    n_cmp++;
    if ({underflow, overflow, depth_count} !== {1'b1, 1'b1, CW'(0)}) begin
      n_err++; $display("FAIL ovf_unf: got unf=%0b ovf=%0b cnt=%0d exp 1/1/0",
                        underflow, overflow, depth_count);
    end
  endtask

  task automatic test_hints();
    do_reset();
    call(32'h40);
    cycle(1, 0, 1, 5'd1, 5'd5, 32'h80, 0, 0, 0);
    n_cmp++;
    if ({pred_target, depth_count} !== {32'h84, CW'(1)}) begin
      n_err++; $display("FAIL hint_poppush: got tgt=%h cnt=%0d exp 00000084/1",
                        pred_target, depth_count);
    end
    cycle(1, 0, 1, 5'd5, 5'd5, 32'h90, 0, 0, 0);
    n_cmp++;
    if ({pred_target, depth_count} !== {32'h94, CW'(2)}) begin
      n_err++; $display("FAIL hint_samelink: got tgt=%h cnt=%0d exp 00000094/2",
                        pred_target, depth_count);
    end
    cycle(1, 1, 0, 5'd0, 5'd0, 32'hA0, 0, 0, 0);
    n_cmp++;
    if (dut_vec() !== model_vec() || depth_count !== CW'(2)) begin
      n_err++; $display("FAIL hint_jal_x0: got %h exp %h", dut_vec(), model_vec());
    end
    // empty-stack POPPUSH: underflow then push
    do_reset();
    cycle(1, 0, 1, 5'd5, 5'd1, 32'hC0, 0, 0, 0);
    n_cmp++;
    if ({underflow, depth_count, pred_target} !== {1'b1, CW'(1), 32'hC4}) begin
      n_err++; $display("FAIL hint_poppush_empty: got unf=%0b cnt=%0d tgt=%h exp 1/1/000000c4",
                        underflow, depth_count, pred_target);
    end
  endtask

  task automatic test_checkpoint();
    do_reset();
    call(32'h0); call(32'h10);
    idle(1, 0, 0);
    call(32'h20);
    ret(); ret();
    idle(0, 1, 0);
    n_cmp++;
    if ({depth_count, pred_target} !== {CW'(2), 32'h14}) begin
      n_err++; $display("FAIL ckpt_restore: got cnt=%0d tgt=%h exp 2/00000014",
                        depth_count, pred_target);
    end
    cycle(1, 1, 0, 5'd1, 5'd0, 32'h300, 0, 0, 1);
    n_cmp++;
    if ({depth_count, pred_target} !== {CW'(2), 32'h14}) begin
      n_err++; $display("FAIL ckpt_restore_drops_push: got cnt=%0d tgt=%h exp 2/00000014",
                        depth_count, pred_target);
    end
  endtask

  task automatic test_flush();
    do_reset();
    ret();
    call(32'h0); call(32'h10); call(32'h20);
    cycle(1, 1, 0, 5'd1, 5'd0, 32'h500, 1, 0, 0);
    n_cmp++;
    if ({pred_valid, depth_count, overflow, underflow} !== {1'b0, CW'(0), 1'b0, 1'b1}) begin
      n_err++; $display("FAIL flush: got pv=%0b cnt=%0d ovf=%0b unf=%0b exp 0/0/0/1",
                        pred_valid, depth_count, overflow, underflow);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    call(32'h600); call(32'h700);
    ret(); ret(); ret();
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (dut_vec() !== {SW{1'b0}}) begin
      n_err++; $display("FAIL async_reset: got %h exp %h", dut_vec(), {SW{1'b0}});
    end
    m_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    call(32'h800);
    n_cmp++;
    if (dut_vec() !== model_vec()) begin
      n_err++; $display("FAIL post_reset_push: got %h exp %h", dut_vec(), model_vec());
    end
  endtask

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 3))
      0:       return 5'd0;
      1:       return 5'd1;
      2:       return 5'd5;
      default: return 5'($urandom);
    endcase
  endfunction

  task automatic test_random();
    bit v, jal, jalr, fl, sv, rs;
    logic [XLEN-1:0] p;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      v    = ($urandom_range(0, 9) != 0);
      jal  = $urandom_range(0, 1);
      jalr = !jal && ($urandom_range(0, 4) != 0);
      fl   = ($urandom_range(0, 49) == 0);
      sv   = ($urandom_range(0, 7) == 0);
      rs   = ($urandom_range(0, 11) == 0);
      p    = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : {$urandom} & 32'hFFFF_FFFC;
      cycle(v, jal, jalr, pick_reg(), pick_reg(), p, fl, sv, rs);
      n_cmp++;
      if (dut_vec() !== model_vec()) begin
        n_err++; $display("FAIL random_c%0d: got %h exp %h", n, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    reset = 1'b0; valid = 0; is_jal = 0; is_jalr = 0; rd = '0; rs1 = '0; pc = '0;
    flush = 0; ckpt_save = 0; ckpt_restore = 0;
    m_reset();
    #3;
    test_reset();
    test_basic();
    test_nesting();
    test_overflow();
    test_hints();
    test_checkpoint();
    test_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/return_addr_stack.md
# return_addr_stack

Parametrised return-address stack (RAS) for the accel_cpu fetch/decode path. It generalises the current JAL/JALR link handling: calls push the return address, returns pop it, and the top entry is offered as a predicted JALR target. It has configurable depth and width, RISC-V link-register hint decoding, circular overwrite on overflow, and a single checkpoint for misprediction recovery. It sits beside the PC-select logic and does not alter architectural state.

## Interface
- XLEN, 32, address width
- DEPTH, 8, number of entries; power of two, >= 2
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- valid  input  1  a control-transfer instruction is presented this cycle
- is_jal  input  1  instruction is JAL (qualified by valid)
- is_jalr  input  1  instruction is JALR (qualified by valid); is_jal and is_jalr are never both 1
- rd  input  5  destination register index
- rs1  input  5  source register index (JALR only)
- pc  input  XLEN  PC of the presented instruction
- flush  input  1  empty the stack
- ckpt_save  input  1  capture pointer and count into the checkpoint
- ckpt_restore  input  1  reload pointer and count from the checkpoint
- pred_valid  output  1  the stack is non-empty
- pred_target  output  XLEN  entry at top of stack
- depth_count  output  $clog2(DEPTH+1)  number of live entries
- overflow  output  1  sticky: a push occurred while full
- underflow  output  1  sticky: a pop occurred while empty

## Operation
- Link register: rd or rs1 in {1, 5}.
- Op decode, when valid is 1:
  - JAL with rd link: PUSH.
  - JAL with rd not link: NONE.
  - JALR, rd not link, rs1 not link: NONE.
  - JALR, rd not link, rs1 link: POP.
  - JALR, rd link, rs1 not link: PUSH.
  - JALR, both link, rd != rs1: POPPUSH.
  - JALR, both link, rd == rs1: PUSH.
- Push value: pc + 4, modulo 2^XLEN.
- State: entry array, top index tos (log2(DEPTH) bits), count, checkpoint {tos, count}.
- PUSH: tos <= tos+1 (wraps), mem[tos+1] <= value, count <= min(count+1, DEPTH).
  - If count == DEPTH beforehand, the oldest entry is overwritten and overflow is set to 1.
- POP with count > 0: tos <= tos-1 (wraps), count <= count-1.
- POP with count == 0: no state change; underflow is set to 1.
- POPPUSH with count > 0: mem[tos] <= value; tos and count unchanged.
- POPPUSH with count == 0: underflow is set to 1, then a normal PUSH is performed.
- Same-cycle priority: flush > ckpt_restore > op.
  - flush: count <= 0, tos <= DEPTH-1. The op is dropped and the checkpoint is unchanged.
  - ckpt_restore: tos and count reload from the checkpoint. The op is dropped.
- ckpt_save captures the tos/count registered at this edge, i.e. the state before this cycle's op.
  - Save is ignored when flush or ckpt_restore is also asserted.
- Checkpoint restore does not restore entry contents; entries overwritten since the save stay overwritten.
- overflow and underflow clear only on reset.

## Timing
- pred_valid = (count != 0) and pred_target = mem[tos], both combinational from registered state.
  - The prediction for a return presented in cycle N uses state before its POP.
- All state updates occur on the rising clk edge and are visible one cycle later (push-to-predict latency 1).
- On reset assertion (async):
  - tos = DEPTH-1, count = 0, checkpoint = {DEPTH-1, 0}, all entries = 0.
  - pred_valid = 0, pred_target = 0, depth_count = 0, overflow = 0, underflow = 0.
- Reset mid-operation discards any pending op. The first edge after reset release may carry a valid op.
- Back-to-back ops every cycle are supported; there is no stall or handshake.

## Test plan
1. Basic push/pop.
   - After reset: pred_valid = 0 and depth_count = 0.
   - JAL rd=1, pc=0x0 -> next cycle pred_valid = 1, pred_target = 0x4, depth_count = 1.
   - JALR rd=0, rs1=1 -> next cycle pred_valid = 0, depth_count = 0, underflow = 0.
2. Nesting with DEPTH=8.
   - JAL rd=1 at pc 0x0, 0x10, 0x20 -> targets 0x24, 0x14, 0x4 are predicted on successive pops; depth_count goes 3 -> 0.
3. Overflow.
   - 9 pushes at pc = 0x100*k, k = 0..8 -> overflow = 1 and depth_count = 8.
   - 8 pops predict 0x804 down to 0x104.
   - A 9th pop sets underflow = 1.
4. Hint cases.
   - JALR rd=1, rs1=5 with the stack holding 0x44, pc=0x80 -> pred_target = 0x84, depth_count unchanged.
   - JALR rd=5, rs1=5 -> depth_count increments.
   - JAL rd=0 -> no change.
5. Checkpoint.
   - Push 0x4 and 0x14, save, push 0x24, pop, pop, restore -> depth_count = 2, pred_target = 0x14.
   - Restore together with a push in the same cycle -> the push is dropped.
6. Flush and reset.
   - flush together with a push while depth_count = 3 -> depth_count = 0 and pred_valid = 0; overflow/underflow keep their values.
   - Assert reset between edges -> all outputs are 0 immediately.
